// File: rtl/instruction_fetcher.sv
// Fetch stage: owns the PC, issues icache requests, predicts the next PC with a 2-bit BHT and
// hands {inst, pc, predict_pc} to the decoder through a one-entry output buffer.
module instruction_fetcher #(
  parameter int unsigned BHT_INDEX_WIDTH = 8,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rollback_in,
  input  logic [31:0] rollback_pc_in,
  input  logic        commit_branch_in,
  input  logic        commit_taken_in,
  input  logic [31:0] commit_pc_in,
  output logic        ic_req_out,
  output logic [31:0] ic_addr_out,
  input  logic        ic_valid_in,
  input  logic [31:0] ic_inst_in,
  input  logic        dec_stall_in,
  output logic        dec_valid_out,
  output logic [31:0] dec_inst_out,
  output logic [31:0] dec_pc_out,
  output logic [31:0] dec_predict_pc_out
);

  localparam int         BhtDepth = 1 << BHT_INDEX_WIDTH;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [1:0] {StIdle, StWait, StFlush} state_e;

  state_e      r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next;
  logic        r_ic_req, w_ic_req_next;
  logic [31:0] r_ic_addr, w_ic_addr_next;
  logic        r_dec_valid, w_dec_valid_next;
  logic [31:0] r_dec_inst, w_dec_inst_next;
  logic [31:0] r_dec_pc, w_dec_pc_next;
  logic [31:0] r_dec_pred, w_dec_pred_next;

  logic [1:0]  r_bht [BhtDepth];

  logic [BHT_INDEX_WIDTH-1:0] w_fetch_idx;
  logic [BHT_INDEX_WIDTH-1:0] w_commit_idx;
  logic [1:0]  w_commit_ctr;
  logic [1:0]  w_commit_ctr_next;
  logic [6:0]  w_opcode;
  logic [31:0] w_imm_j;
  logic [31:0] w_imm_b;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_npc;
  logic        w_consume;
  logic        w_unused;

  assign w_fetch_idx  = r_pc[BHT_INDEX_WIDTH+1:2];
  assign w_commit_idx = commit_pc_in[BHT_INDEX_WIDTH+1:2];
  assign w_unused     = ^{commit_pc_in[31:BHT_INDEX_WIDTH+2], commit_pc_in[1:0]};

  // Next-PC prediction for the word arriving from the icache; r_pc is its fetch address.
  assign w_opcode   = ic_inst_in[6:0];
  assign w_imm_j    = {{12{ic_inst_in[31]}}, ic_inst_in[19:12], ic_inst_in[20],
                       ic_inst_in[30:21], 1'b0};
  assign w_imm_b    = {{20{ic_inst_in[31]}}, ic_inst_in[7], ic_inst_in[30:25],
                       ic_inst_in[11:8], 1'b0};
  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    w_npc = w_pc_plus4;
    case (w_opcode)
      OpJal:    w_npc = r_pc + w_imm_j;
      OpBranch: w_npc = r_bht[w_fetch_idx][1] ? (r_pc + w_imm_b) : w_pc_plus4;
      default:  w_npc = w_pc_plus4;
    endcase
  end

  // Saturating 2-bit counter update for the committed branch.
  always_comb begin
    w_commit_ctr      = r_bht[w_commit_idx];
    w_commit_ctr_next = w_commit_ctr;
    if (commit_taken_in) begin
      if (w_commit_ctr != 2'b11) w_commit_ctr_next = w_commit_ctr + 2'd1;
    end else begin
      if (w_commit_ctr != 2'b00) w_commit_ctr_next = w_commit_ctr - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BhtDepth; i++) r_bht[i] <= 2'b01;
    end else if (commit_branch_in) begin
      r_bht[w_commit_idx] <= w_commit_ctr_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_ic_req_next    = r_ic_req;
    w_ic_addr_next   = r_ic_addr;
    w_dec_valid_next = r_dec_valid;
    w_dec_inst_next  = r_dec_inst;
    w_dec_pc_next    = r_dec_pc;
    w_dec_pred_next  = r_dec_pred;

    w_consume = r_dec_valid && !dec_stall_in;
    if (w_consume) w_dec_valid_next = 1'b0;

    case (r_state)
      StIdle: begin
        if (!r_dec_valid || w_consume) begin
          w_ic_req_next  = 1'b1;
          w_ic_addr_next = r_pc;
          w_state_next   = StWait;
        end
      end
      StWait: begin
        if (ic_valid_in) begin
          w_dec_valid_next = 1'b1;
          w_dec_inst_next  = ic_inst_in;
          w_dec_pc_next    = r_pc;
          w_dec_pred_next  = w_npc;
          w_pc_next        = w_npc;
          w_ic_req_next    = 1'b0;
          w_state_next     = StIdle;
        end
      end
      StFlush: begin
        if (ic_valid_in) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase

    // Rollback wins over everything but reset; an outstanding request must still drain.
    if (rollback_in) begin
      w_pc_next        = rollback_pc_in;
      w_dec_valid_next = 1'b0;
      w_ic_req_next    = 1'b0;
      w_ic_addr_next   = r_ic_addr;
      w_dec_inst_next  = r_dec_inst;
      w_dec_pc_next    = r_dec_pc;
      w_dec_pred_next  = r_dec_pred;
      w_state_next     = ((r_state != StIdle) && !ic_valid_in) ? StFlush : StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_pc        <= RESET_PC;
      r_ic_req    <= 1'b0;
      r_ic_addr   <= 32'h0;
      r_dec_valid <= 1'b0;
      r_dec_inst  <= 32'h0;
      r_dec_pc    <= 32'h0;
      r_dec_pred  <= 32'h0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_ic_req    <= w_ic_req_next;
      r_ic_addr   <= w_ic_addr_next;
      r_dec_valid <= w_dec_valid_next;
      r_dec_inst  <= w_dec_inst_next;
      r_dec_pc    <= w_dec_pc_next;
      r_dec_pred  <= w_dec_pred_next;
    end
  end

  assign ic_req_out         = r_ic_req;
  assign ic_addr_out        = r_ic_addr;
  assign dec_valid_out      = r_dec_valid;
  assign dec_inst_out       = r_dec_inst;
  assign dec_pc_out         = r_dec_pc;
  assign dec_predict_pc_out = r_dec_pred;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Bench for instruction_fetcher: icache responder plus a transaction-level model of the fetch
// stream, BHT counters and output buffer; directed scenarios followed by random traffic.
module tb_instruction_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        rollback_in;
  logic [31:0] rollback_pc_in;
  logic        commit_branch_in;
  logic        commit_taken_in;
  logic [31:0] commit_pc_in;
  logic        ic_req_out;
  logic [31:0] ic_addr_out;
  logic        ic_valid_in;
  logic [31:0] ic_inst_in;
  logic        dec_stall_in;
  logic        dec_valid_out;
  logic [31:0] dec_inst_out;
  logic [31:0] dec_pc_out;
  logic [31:0] dec_predict_pc_out;

  always #5 clk = ~clk;

  instruction_fetcher #(
    .BHT_INDEX_WIDTH(8),
    .RESET_PC       (32'h0)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .rollback_in       (rollback_in),
    .rollback_pc_in    (rollback_pc_in),
    .commit_branch_in  (commit_branch_in),
    .commit_taken_in   (commit_taken_in),
    .commit_pc_in      (commit_pc_in),
    .ic_req_out        (ic_req_out),
    .ic_addr_out       (ic_addr_out),
    .ic_valid_in       (ic_valid_in),
    .ic_inst_in        (ic_inst_in),
    .dec_stall_in      (dec_stall_in),
    .dec_valid_out     (dec_valid_out),
    .dec_inst_out      (dec_inst_out),
    .dec_pc_out        (dec_pc_out),
    .dec_predict_pc_out(dec_predict_pc_out)
  );

  int checks = 0;
  int errors = 0;

  // Icache: a word per address, random (biased towards control flow) unless preset.
  logic [31:0] imem [logic [31:0]];
  bit          ic_pend = 0;
  bit          ic_live = 0;
  int          ic_cnt  = 0;
  int          ic_lat  = 1;
  logic [31:0] ic_paddr;

  // Model: next fetch PC, counters, and the single buffered entry.
  logic [31:0] m_pc;
  int          m_bht [256];
  bit          m_valid = 0;
  logic [31:0] m_inst, m_ipc, m_pred;
  int          n_resp = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fetch_word(input logic [31:0] a);
    logic [31:0] w;
    if (!imem.exists(a)) begin
      w = $urandom;
      case ($urandom_range(0, 3))
        0:       w[6:0] = 7'b1101111;
        1:       w[6:0] = 7'b1100011;
        2:       w[6:0] = 7'b1100111;
        default: w[6:0] = 7'b0010011;
      endcase
      imem[a] = w;
    end
    return imem[a];
  endfunction

  function automatic int bht_idx(input logic [31:0] pc);
    return int'((pc / 4) % 256);
  endfunction

  function automatic logic [31:0] exp_npc(input logic [31:0] inst, input logic [31:0] pc);
    int imm;
    case (inst[6:0])
      7'b1101111: begin
        imm = 2 * int'(inst[30:21]) + 2048 * int'(inst[20]) + 4096 * int'(inst[19:12]);
        if (inst[31]) imm -= (1 << 20);
        return pc + 32'(imm);
      end
      7'b1100011: begin
        imm = 2 * int'(inst[11:8]) + 32 * int'(inst[30:25]) + 2048 * int'(inst[7]);
        if (inst[31]) imm -= 4096;
        if (m_bht[bht_idx(pc)] >= 2) return pc + 32'(imm);
        return pc + 32'd4;
      end
      default: return pc + 32'd4;
    endcase
  endfunction

  // One clock: update the model from this cycle's inputs, cross the edge, then run the
  // icache responder and compare the visible state against the model.
  task automatic tick();
    int k;
    if (rst) begin
      m_pc    = 32'h0;
      m_valid = 0;
      for (int i = 0; i < 256; i++) m_bht[i] = 1;
    end else begin
      if (m_valid && !dec_stall_in) m_valid = 0;
      if (ic_valid_in && ic_live && !rollback_in) begin
        m_inst  = ic_inst_in;
        m_ipc   = ic_paddr;
        m_pred  = exp_npc(ic_inst_in, ic_paddr);
        m_pc    = m_pred;
        m_valid = 1;
        n_resp++;
      end
      if (rollback_in) begin
        m_pc    = rollback_pc_in;
        m_valid = 0;
        ic_live = 0;
      end
      if (commit_branch_in) begin
        k = bht_idx(commit_pc_in);
        if (commit_taken_in) m_bht[k] = (m_bht[k] == 3) ? 3 : m_bht[k] + 1;
        else                 m_bht[k] = (m_bht[k] == 0) ? 0 : m_bht[k] - 1;
      end
    end

    @(posedge clk);
    #1;

    if (rst) begin
      ic_pend     = 0;
      ic_live     = 0;
      ic_valid_in = 1'b0;
    end else if (ic_valid_in) begin
      ic_valid_in = 1'b0;
      ic_pend     = 0;
      ic_live     = 0;
    end else if (ic_pend) begin
      if (ic_cnt == 0) begin
        ic_valid_in = 1'b1;
        ic_inst_in  = fetch_word(ic_paddr);
      end else begin
        ic_cnt--;
      end
    end

    if (!rst && !ic_pend && ic_req_out) begin
      ic_pend  = 1;
      ic_live  = 1;
      ic_paddr = ic_addr_out;
      ic_cnt   = ic_lat;
      chk("req_addr", ic_addr_out, m_pc);
    end else if (ic_pend && ic_live) begin
      chk("req_held", ic_req_out, 1'b1);
      chk("req_addr_stable", ic_addr_out, ic_paddr);
    end

    chk("dec_valid", dec_valid_out, m_valid);
    if (m_valid) begin
      chk("dec_inst", dec_inst_out, m_inst);
      chk("dec_pc", dec_pc_out, m_ipc);
      chk("dec_pred", dec_predict_pc_out, m_pred);
    end
  endtask

  task automatic wait_dec(input string tag, input logic [31:0] pc, input logic [31:0] pred);
    int n = 0;
    while (!(dec_valid_out && dec_pc_out == pc) && n < 80) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, dec_valid_out, 1'b1);
    chk({tag, "_pc"}, dec_pc_out, pc);
    chk({tag, "_pred"}, dec_predict_pc_out, pred);
  endtask

  task automatic wait_req(input string tag, input logic [31:0] addr);
    int n = 0;
    while (!ic_req_out && n < 80) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, ic_req_out, 1'b1);
    chk({tag, "_addr"}, ic_addr_out, addr);
  endtask

  task automatic do_rollback(input logic [31:0] pc);
    rollback_in    = 1'b1;
    rollback_pc_in = pc;
    tick();
    rollback_in    = 1'b0;
  endtask

  task automatic do_commit(input logic [31:0] pc, input logic taken, input int times);
    commit_branch_in = 1'b1;
    commit_pc_in     = pc;
    commit_taken_in  = taken;
    for (int i = 0; i < times; i++) tick();
    commit_branch_in = 1'b0;
  endtask

  logic [31:0] s_inst, s_pc, s_pred;

  initial begin
    rst = 1'b1;  rollback_in = 1'b0;  rollback_pc_in = '0;
    commit_branch_in = 1'b0;  commit_taken_in = 1'b0;  commit_pc_in = '0;
    ic_valid_in = 1'b0;  ic_inst_in = '0;  dec_stall_in = 1'b0;

    for (int a = 0; a < 'h40; a += 4) imem[a] = 32'h00000013;
    for (int a = 'h100; a < 'h140; a += 4) imem[a] = 32'h00000013;
    imem[32'h10] = 32'h00000463;  // beq x0,x0,+8
    imem[32'h20] = 32'hff1ff06f;  // jal x0,-16
    imem[32'h24] = 32'h00008067;  // jalr x0,0(x1)

    tick();
    tick();
    chk("rst_req", ic_req_out, 1'b0);
    chk("rst_addr", ic_addr_out, 32'h0);
    chk("rst_valid", dec_valid_out, 1'b0);
    chk("rst_inst", dec_inst_out, 32'h0);
    chk("rst_pc", dec_pc_out, 32'h0);
    chk("rst_pred", dec_predict_pc_out, 32'h0);
    rst = 1'b0;

    wait_req("first", 32'h0);
    wait_dec("nop0", 32'h0, 32'h4);
    chk("nop0_inst", dec_inst_out, 32'h00000013);
    wait_req("second", 32'h4);

    wait_dec("beq_wnt", 32'h10, 32'h14);
    do_commit(32'h10, 1'b1, 2);
    do_rollback(32'h10);
    wait_dec("beq_st", 32'h10, 32'h18);
    do_commit(32'h10, 1'b0, 8);
    do_rollback(32'h10);
    wait_dec("beq_sat0", 32'h10, 32'h14);
    do_commit(32'h10, 1'b1, 1);
    do_rollback(32'h10);
    wait_dec("beq_c01", 32'h10, 32'h14);
    do_commit(32'h10, 1'b1, 1);
    do_rollback(32'h10);
    wait_dec("beq_c10", 32'h10, 32'h18);

    do_rollback(32'h20);
    wait_dec("jal", 32'h20, 32'h10);
    do_rollback(32'h24);
    wait_dec("jalr", 32'h24, 32'h28);

    // Hold the full buffer under stall, then release.
    dec_stall_in = 1'b1;
    s_inst = dec_inst_out;  s_pc = dec_pc_out;  s_pred = dec_predict_pc_out;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_noreq", ic_req_out, 1'b0);
      chk("stall_inst", dec_inst_out, s_inst);
      chk("stall_pc", dec_pc_out, s_pc);
      chk("stall_pred", dec_predict_pc_out, s_pred);
    end
    dec_stall_in = 1'b0;
    tick();
    chk("release_req", ic_req_out, 1'b1);
    chk("release_valid", dec_valid_out, 1'b0);

    // Rollback while the request is outstanding; the late word must be dropped.
    do_rollback(32'h100);
    chk("rb_wait_valid", dec_valid_out, 1'b0);
    chk("rb_wait_req", ic_req_out, 1'b0);
    wait_req("rb_wait_next", 32'h100);

    // Rollback coinciding with the icache response.
    for (int i = 0; i < 40 && !ic_valid_in; i++) tick();
    chk("resp_pending", ic_valid_in, 1'b1);
    do_rollback(32'h200);
    chk("rb_resp_valid", dec_valid_out, 1'b0);
    wait_req("rb_resp_next", 32'h200);

    // Reset beats a simultaneous rollback.
    rst = 1'b1;
    rollback_in = 1'b1;
    rollback_pc_in = 32'h300;
    tick();
    rst = 1'b0;
    rollback_in = 1'b0;
    wait_req("rst_rb", 32'h0);

    // Random traffic against the model.
    n_resp = 0;
    for (int c = 0; c < 4000; c++) begin
      dec_stall_in     = ($urandom_range(0, 3) == 0);
      commit_branch_in = ($urandom_range(0, 2) == 0);
      commit_taken_in  = $urandom_range(0, 1);
      commit_pc_in     = {$urandom_range(0, 3), 20'h0, 8'($urandom_range(0, 255)), 2'b00};
      rollback_in      = ($urandom_range(0, 49) == 0);
      rollback_pc_in   = 32'($urandom_range(0, 2047)) * 4;
      ic_lat           = $urandom_range(0, 3);
      tick();
    end
    rollback_in = 1'b0;
    commit_branch_in = 1'b0;
    dec_stall_in = 1'b0;
    chk("random_progress", 32'(n_resp >= 200), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
